// File: rtl/demux_1to16_dist_if.sv
// demux_1to16_dist_if
//   Bundles the word handshake, the 16 per-channel holding outputs and the
//   consumer acknowledges of the 1-to-16 byte distributor.
//   Signals:
//     in_valid   source presents a (channel, byte) word
//     in_ready   distributor can accept the word this cycle
//     in_sel     target channel 0..15
//     in_data    byte to deliver
//     ch_data    flattened holding registers, channel i at [i*DATA_W +: DATA_W]
//     ch_valid   per-channel "data held" flags
//     ch_ack     per-channel consume strobes
//     sel_ptr    auto-select pointer (0 when auto-select is compiled out)
//     frame_done one-cycle pulse after a word lands in channel 15
//   Modports: master = source/consumer side, slave = distributor.
interface demux_1to16_dist_if #(
  parameter int DATA_W = 8
);
  logic                 in_valid;
  logic                 in_ready;
  logic [3:0]           in_sel;
  logic [DATA_W-1:0]    in_data;
  logic [16*DATA_W-1:0] ch_data;
  logic [15:0]          ch_valid;
  logic [15:0]          ch_ack;
  logic [3:0]           sel_ptr;
  logic                 frame_done;

  modport master (
    output in_valid, in_sel, in_data, ch_ack,
    input  in_ready, ch_data, ch_valid, sel_ptr, frame_done
  );

  modport slave (
    input  in_valid, in_sel, in_data, ch_ack,
    output in_ready, ch_data, ch_valid, sel_ptr, frame_done
  );
endinterface

// File: rtl/demux_1to16_dist.sv
// demux_1to16_dist
//   Registered 1-to-16 byte distributor. Accepted (channel, byte) words are
//   written into one of 16 holding registers, each with its own valid flag
//   that the consumer clears through ch_ack. A full, un-acked channel stalls
//   the source through in_ready; an ack in the same cycle frees the channel
//   so a new byte can land immediately (write wins over ack).
//   Ports:
//     clk  system clock, rising edge
//     rst  synchronous active-high reset
//     bus  demux_1to16_dist_if.slave (handshake, channel outputs, acks)
//   Build option:
//     DEMUX_AUTOSEL_EN  when defined, in_sel is ignored and the channel comes
//                       from an internal round-robin pointer (sel_ptr).
module demux_1to16_dist #(
  parameter int DATA_W = 8
) (
  input logic               clk,
  input logic               rst,
  demux_1to16_dist_if.slave bus
);

  logic [DATA_W-1:0] ch_data_p1 [16];
  logic [15:0]       ch_valid_p1;
  logic              frame_done_p1;
  logic [3:0]        sel;
  logic              accept;

`ifdef DEMUX_AUTOSEL_EN
  logic [3:0] sel_ptr_p1;
  logic       unused_in_sel;

  assign unused_in_sel = ^bus.in_sel;
  assign sel           = sel_ptr_p1;
  assign bus.sel_ptr   = sel_ptr_p1;

  // Pointer advances only on accept, so it holds while stalled; wraps 15 -> 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      sel_ptr_p1 <= 4'h0;
    end else if (accept) begin
      sel_ptr_p1 <= sel_ptr_p1 + 4'h1;
    end
  end
`else
  assign sel         = bus.in_sel;
  assign bus.sel_ptr = 4'h0;
`endif

  // An ack on the selected channel frees it in the same cycle.
  assign bus.in_ready = !rst && (!ch_valid_p1[sel] || bus.ch_ack[sel]);
  assign accept       = bus.in_valid && bus.in_ready;

  // ---- stage p1: holding registers, flags and frame pulse ----
  always_ff @(posedge clk) begin
    if (rst) begin
      ch_valid_p1   <= '0;
      frame_done_p1 <= 1'b0;
      for (int i = 0; i < 16; i++) begin
        ch_data_p1[i] <= '0;
      end
    end else begin
      // Acks clear first; the write below overrides for the selected channel.
      ch_valid_p1   <= (ch_valid_p1 & ~bus.ch_ack) | (accept ? (16'h1 << sel) : 16'h0);
      frame_done_p1 <= accept && (sel == 4'd15);
      if (accept) begin
        ch_data_p1[sel] <= bus.in_data;
      end
    end
  end

  for (genvar g = 0; g < 16; g++) begin : g_pack
    assign bus.ch_data[g*DATA_W +: DATA_W] = ch_data_p1[g];
  end

  assign bus.ch_valid   = ch_valid_p1;
  assign bus.frame_done = frame_done_p1;

endmodule
